// File: rtl/seg7_scan_driver_pkg.sv
// Seven-segment code constants and segment bit positions shared by the scan driver.
// Codes are active-high (bit0=a .. bit6=g); pin polarity is applied in the top.
package seg7_scan_driver_pkg;

  localparam int SEG_BIT_A = 0;
  localparam int SEG_BIT_B = 1;
  localparam int SEG_BIT_C = 2;
  localparam int SEG_BIT_D = 3;
  localparam int SEG_BIT_E = 4;
  localparam int SEG_BIT_F = 5;
  localparam int SEG_BIT_G = 6;

  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  // Every segment lit: built from the bit names so they stay in step with the codes.
  localparam logic [6:0] SEG_8   = 7'((1 << SEG_BIT_A) | (1 << SEG_BIT_B) | (1 << SEG_BIT_C) |
                                      (1 << SEG_BIT_D) | (1 << SEG_BIT_E) | (1 << SEG_BIT_F) |
                                      (1 << SEG_BIT_G));
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;

  // Convert an active-high code into the level driven onto the pins.
  function automatic logic [6:0] seg_pin(input logic [6:0] code, input logic inv);
    return inv ? ~code : code;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_decode.sv
// Hex nibble to active-high seven-segment code (0-9, A, b, C, d, E, F).
// Purely combinational, no latency, no flow control.
module seg7_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] code
);

  always_comb begin
    code = SEG_OFF;
    case (nibble)
      4'h0: code = SEG_0;
      4'h1: code = SEG_1;
      4'h2: code = SEG_2;
      4'h3: code = SEG_3;
      4'h4: code = SEG_4;
      4'h5: code = SEG_5;
      4'h6: code = SEG_6;
      4'h7: code = SEG_7;
      4'h8: code = SEG_8;
      4'h9: code = SEG_9;
      4'hA: code = SEG_A;
      4'hB: code = SEG_B;
      4'hC: code = SEG_C;
      4'hD: code = SEG_D;
      4'hE: code = SEG_E;
      4'hF: code = SEG_F;
      default: code = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver with frame-boundary commit, LZ blanking and dead time.
// Pins are registered one cycle after scan state; load is always accepted (no backpressure).
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEAD_CYC = 16,
  parameter bit SEG_INV  = 1'b1,
  parameter bit AN_INV   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_en,
  output logic                  pending,
  output logic                  frame_start,
  output logic [6:0]            seg,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     an
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VAL_W = 4 * DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]  div_cnt;
  logic [IDX_W-1:0]  idx;
  logic              terminal;
  logic              boundary;

  logic [VAL_W-1:0]  shadow_val;
  logic [DIGITS-1:0] shadow_dp;
  logic [DIGITS-1:0] shadow_blank;
  logic              shadow_lz;

  logic [VAL_W-1:0]  live_val;
  logic [DIGITS-1:0] live_dp;
  logic [DIGITS-1:0] live_blank;
  logic              live_lz;

  logic [DIGITS-1:0] lz_show;
  logic              lz_seen;
  logic [3:0]        slot_nib;
  logic              slot_show;
  logic              slot_dp;
  logic [6:0]        dec_code;
  logic [6:0]        seg_nxt;
  logic [DIGITS-1:0] an_nxt;

  always_comb begin
    terminal = (div_cnt == CNT_LAST);
    boundary = terminal && (idx == IDX_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (terminal) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  // Shadow always follows the latest load; repeated loads simply overwrite it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val   <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      shadow_lz    <= 1'b0;
    end else if (load) begin
      shadow_val   <= value;
      shadow_dp    <= dp;
      shadow_blank <= blank;
      shadow_lz    <= lz_en;
    end
  end

  // Live only changes at the frame boundary so a frame never mixes old and new data.
  // A load landing on the boundary itself bypasses the shadow and never raises pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_val    <= '0;
      live_dp     <= '0;
      live_blank  <= '0;
      live_lz     <= 1'b1;
      pending     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
      if (boundary) begin
        pending <= 1'b0;
        if (load) begin
          live_val   <= value;
          live_dp    <= dp;
          live_blank <= blank;
          live_lz    <= lz_en;
        end else if (pending) begin
          live_val   <= shadow_val;
          live_dp    <= shadow_dp;
          live_blank <= shadow_blank;
          live_lz    <= shadow_lz;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Scan from the top digit down; once a nonzero nibble is seen everything below is shown.
  always_comb begin
    lz_seen = 1'b0;
    lz_show = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lz_seen    = lz_seen | (live_val[4*k +: 4] != 4'h0);
      lz_show[k] = lz_seen || (k == 0) || !live_lz;
    end
  end

  always_comb begin
    slot_nib  = 4'h0;
    slot_show = 1'b0;
    slot_dp   = 1'b0;
    an_nxt    = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        slot_nib  = live_val[4*k +: 4];
        slot_show = lz_show[k] && !live_blank[k];
        slot_dp   = live_dp[k] && !live_blank[k];
        an_nxt[k] = (div_cnt >= CNT_DEAD);
      end
    end
  end

  seg7_decode u_decode (
    .nibble (slot_nib),
    .code   (dec_code)
  );

  always_comb seg_nxt = slot_show ? dec_code : SEG_OFF;

  // Polarity is folded in ahead of the flops so the pins come straight off registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg  <= seg_pin(SEG_OFF, SEG_INV);
      dp_o <= SEG_INV;
      an   <= {DIGITS{AN_INV}};
    end else begin
      seg  <= seg_pin(seg_nxt, SEG_INV);
      dp_o <= slot_dp ^ SEG_INV;
      an   <= an_nxt ^ {DIGITS{AN_INV}};
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: 4 digits, 8-cycle slots, 2-cycle dead time, active-low pins.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic        lz_en = 1'b0;
  logic        pending;
  logic        frame_start;
  logic [6:0]  seg;
  logic        dp_o;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic            lz;
    logic [3:0][6:0] seg;   // expected pin-level seg per digit, index = digit
    logic [3:0]      dpo;   // expected pin-level dp per digit
  } vec_t;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
  } exp_t;

  exp_t sb[$];
  vec_t vt[9];

  seg7_scan_driver #(
    .DIGITS   (4),
    .SCAN_DIV (8),
    .DEAD_CYC (2),
    .SEG_INV  (1'b1),
    .AN_INV   (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .value       (value),
    .dp          (dp),
    .blank       (blank),
    .lz_en       (lz_en),
    .pending     (pending),
    .frame_start (frame_start),
    .seg         (seg),
    .dp_o        (dp_o),
    .an          (an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic push_vec(input vec_t v);
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e.seg = v.seg[k];
      e.dp  = v.dpo[k];
      e.an  = 4'(~(4'b0001 << k));
      sb.push_back(e);
    end
  endtask

  task automatic wait_frame(input string name);
    int b;
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!frame_start && b < 64);
    if (!frame_start) timeout(name);
  endtask

  // Pops one scoreboard entry per digit as each anode comes on, and counts its lit cycles.
  task automatic check_digits(input string tag);
    int   b;
    int   n;
    exp_t e;
    b = 0;
    while (an != 4'hF && b < 20) begin @(negedge clk); b++; end
    for (int k = 0; k < 4; k++) begin
      if (sb.size() == 0) begin
        timeout($sformatf("%s_sb_empty", tag));
        return;
      end
      e = sb.pop_front();
      b = 0;
      while (an == 4'hF && b < 20) begin @(negedge clk); b++; end
      if (an == 4'hF) begin
        timeout($sformatf("%s_d%0d_anode", tag, k));
        continue;
      end
      chk($sformatf("%s_d%0d_seg", tag, k), 32'(seg), 32'(e.seg));
      chk($sformatf("%s_d%0d_dp", tag, k), 32'(dp_o), 32'(e.dp));
      chk($sformatf("%s_d%0d_an", tag, k), 32'(an), 32'(e.an));
      n = 0;
      while (an != 4'hF && n < 20) begin n++; @(negedge clk); end
      chk($sformatf("%s_d%0d_on_cycles", tag, k), 32'(n), 32'd6);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    repeat (4) @(posedge clk);
    #1;
    value = v.value; dp = v.dp; blank = v.blank; lz_en = v.lz; load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0; value = ~v.value; dp = ~v.dp; blank = ~v.blank; lz_en = ~v.lz;
    push_vec(v);
    @(negedge clk);
    chk({tag, "_pending_set"}, 32'(pending), 32'd1);
    wait_frame({tag, "_frame"});
    chk({tag, "_pending_clr"}, 32'(pending), 32'd0);
    check_digits(tag);
  endtask

  initial begin
    vec_t two;
    vec_t bnd;
    int   n;
    int   b;

    vt[0] = '{value:16'h12AF, dp:4'h0, blank:4'h0, lz:1'b0,
              seg:{7'h79, 7'h24, 7'h08, 7'h0E}, dpo:4'hF};
    vt[1] = '{value:16'h0030, dp:4'h0, blank:4'h0, lz:1'b1,
              seg:{7'h7F, 7'h7F, 7'h30, 7'h40}, dpo:4'hF};
    vt[2] = '{value:16'h12AF, dp:4'b0011, blank:4'b0010, lz:1'b0,
              seg:{7'h79, 7'h24, 7'h7F, 7'h0E}, dpo:4'b1110};
    vt[3] = '{value:16'h0000, dp:4'b1000, blank:4'h0, lz:1'b1,
              seg:{7'h7F, 7'h7F, 7'h7F, 7'h40}, dpo:4'b0111};
    vt[4] = '{value:16'h8000, dp:4'h0, blank:4'h0, lz:1'b1,
              seg:{7'h00, 7'h40, 7'h40, 7'h40}, dpo:4'hF};
    vt[5] = '{value:16'h0000, dp:4'h0, blank:4'h0, lz:1'b0,
              seg:{7'h40, 7'h40, 7'h40, 7'h40}, dpo:4'hF};
    vt[6] = '{value:16'h5D9C, dp:4'h0, blank:4'h0, lz:1'b0,
              seg:{7'h12, 7'h21, 7'h10, 7'h46}, dpo:4'hF};
    vt[7] = '{value:16'h3B64, dp:4'h0, blank:4'h0, lz:1'b1,
              seg:{7'h30, 7'h03, 7'h02, 7'h19}, dpo:4'hF};
    vt[8] = '{value:16'h070E, dp:4'h0, blank:4'h0, lz:1'b1,
              seg:{7'h7F, 7'h78, 7'h40, 7'h06}, dpo:4'hF};
    two   = '{value:16'h2222, dp:4'h0, blank:4'h0, lz:1'b0,
              seg:{7'h24, 7'h24, 7'h24, 7'h24}, dpo:4'hF};
    bnd   = '{value:16'h4B07, dp:4'b0100, blank:4'h0, lz:1'b0,
              seg:{7'h19, 7'h03, 7'h40, 7'h78}, dpo:4'b1011};

    // Reset held with the clock running: every pin inactive.
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp_o), 32'd1);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!frame_start && n < 100);
    chk("first_frame_start_cycles", 32'(n), 32'd32);

    for (int i = 0; i < 9; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Two loads inside one frame: the second one is what reaches the display.
    repeat (3) @(posedge clk);
    #1 value = 16'h1111; dp = '0; blank = '0; lz_en = 1'b0; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (5) @(posedge clk);
    #1 value = 16'h2222; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0; value = 16'h1111;
    push_vec(two);
    @(negedge clk);
    chk("two_pending_set", 32'(pending), 32'd1);
    wait_frame("two_frame");
    chk("two_pending_clr", 32'(pending), 32'd0);
    check_digits("two");

    // Load on the exact boundary cycle commits immediately without raising pending.
    wait_frame("bnd_sync");
    repeat (31) @(posedge clk);
    #1 value = bnd.value; dp = bnd.dp; blank = bnd.blank; lz_en = bnd.lz; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0; value = 16'hFFFF; dp = 4'h0; blank = 4'hF; lz_en = 1'b1;
    push_vec(bnd);
    @(negedge clk);
    chk("bnd_pending", 32'(pending), 32'd0);
    chk("bnd_frame_start", 32'(frame_start), 32'd1);
    check_digits("bnd");

    // Asynchronous reset in the middle of a lit slot.
    repeat (3) @(posedge clk);
    #1 value = 16'h0088; dp = 4'hF; blank = 4'h0; lz_en = 1'b0; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
    chk("arst_pending_pre", 32'(pending), 32'd1);
    b = 0;
    while (an == 4'hF && b < 20) begin @(negedge clk); b++; end
    if (an == 4'hF) timeout("arst_anode");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seg", 32'(seg), 32'h7F);
    chk("arst_dp", 32'(dp_o), 32'd1);
    chk("arst_an", 32'(an), 32'hF);
    chk("arst_pending", 32'(pending), 32'd0);
    chk("arst_frame_start", 32'(frame_start), 32'd0);
    #20 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
